// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control unit: sequences fetch, decode, memory, ALU and
// jump steps, driving datapath mux selects and write enables each cycle.
module mc_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       adr_src,
    output logic       pc_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       illegal,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JLINK    = 4'd12,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       reg_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    // Pure state-decoded controls; registered by decoding the next state.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR, S_JALR: begin
                c.alu_src_a  = 2'b10;
                c.alu_src_b  = 2'b01;
                c.result_src = (s == S_JALR) ? 2'b10 : 2'b00;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_ALUWB:   c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
            end
            S_JAL, S_JLINK: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
            end
            S_ILLEGAL: c.illegal = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    state_t cur;
    state_t nxt;
    ctrl_t  ctrl;
    logic   taken;

    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH:    if (mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_RTYPE:          nxt = S_EXECR;
                    OP_ITYPE:          nxt = S_EXECI;
                    OP_BRANCH:         nxt = (funct3[2:1] == 2'b00) ? S_BRANCH : S_ILLEGAL;
                    OP_JAL:            nxt = S_JAL;
                    OP_JALR:           nxt = S_JALR;
                    default:           nxt = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) nxt = S_MEMWB;
            S_MEMWRITE: if (mem_ready) nxt = S_FETCH;
            S_MEMWB, S_ALUWB, S_BRANCH:  nxt = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_JLINK: nxt = S_ALUWB;
            S_JALR:     nxt = S_JLINK;
            S_ILLEGAL:  nxt = S_ILLEGAL;
            default:    nxt = S_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur  <= S_FETCH;
            ctrl <= decode(S_FETCH);
        end else begin
            cur  <= nxt;
            ctrl <= decode(nxt);
        end
    end

    // Enables that depend on inputs are gated by rst_n so nothing writes
    // while reset is held, even though FETCH would otherwise follow mem_ready.
    assign taken      = funct3[0] ? ~zero : zero;
    assign ir_write   = rst_n && (cur == S_FETCH) && mem_ready;
    assign pc_write   = rst_n && (((cur == S_FETCH) && mem_ready) ||
                                  ((cur == S_BRANCH) && taken) ||
                                  (cur == S_JAL) || (cur == S_JALR));
    assign instr_done = rst_n && (cur != S_FETCH) && (nxt == S_FETCH);

    always_comb begin
        case (op)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

    assign mem_req    = ctrl.mem_req;
    assign mem_write  = ctrl.mem_write;
    assign reg_write  = ctrl.reg_write;
    assign adr_src    = ctrl.adr_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign result_src = ctrl.result_src;
    assign alu_op     = ctrl.alu_op;
    assign illegal    = ctrl.illegal;
    assign state      = cur;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: expected per-cycle output vectors are
// queued as stimulus is applied and compared at the following falling edge.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, ir_write, reg_write, adr_src, pc_write;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op, imm_src;
    logic       illegal, instr_done;
    logic [3:0] state;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .adr_src(adr_src),
        .pc_write(pc_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_op(alu_op), .imm_src(imm_src),
        .illegal(illegal), .instr_done(instr_done), .state(state)
    );

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] BAD  = 7'b1111111;

    logic [21:0] expq[$];
    logic [21:0] act;
    int n_tests = 0;
    int n_fail  = 0;
    int mw_cnt, rw_cnt, pw_cnt, done_cnt;

    assign act = {state, mem_req, mem_write, ir_write, reg_write, adr_src, pc_write,
                  alu_src_a, alu_src_b, result_src, alu_op, imm_src, illegal, instr_done};

    // Reference outputs written straight from the per-state control table.
    function automatic logic [21:0] exp_out(input logic [3:0] st, input logic [3:0] nst,
                                            input logic [6:0] o, input logic [2:0] f3,
                                            input logic z, input logic mr);
        logic mreq, mw, irw, rw, adr, pcw, ill, done;
        logic [1:0] a, b, rs, alu, imm;
        mreq = 0; mw = 0; irw = 0; rw = 0; adr = 0; pcw = 0; ill = 0;
        a = 0; b = 0; rs = 0; alu = 0;
        case (st)
            4'd0:  begin mreq = 1; b = 2; rs = 2; irw = mr; pcw = mr; end
            4'd1:  begin a = 1; b = 1; end
            4'd2:  begin a = 2; b = 1; end
            4'd3:  begin mreq = 1; adr = 1; end
            4'd4:  begin rs = 1; rw = 1; end
            4'd5:  begin mreq = 1; adr = 1; mw = 1; end
            4'd6:  begin a = 2; alu = 2; end
            4'd7:  begin a = 2; b = 1; alu = 2; end
            4'd8:  begin rw = 1; end
            4'd9:  begin a = 2; alu = 1; pcw = f3[0] ? ~z : z; end
            4'd10: begin a = 1; b = 2; pcw = 1; end
            4'd11: begin a = 2; b = 1; rs = 2; pcw = 1; end
            4'd12: begin a = 1; b = 2; end
            4'd15: begin ill = 1; end
            default: ;
        endcase
        case (o)
            7'b0100011: imm = 2'b01;
            7'b1100011: imm = 2'b10;
            7'b1101111: imm = 2'b11;
            default:    imm = 2'b00;
        endcase
        done = (st != 4'd0) && (nst == 4'd0);
        return {st, mreq, mw, irw, rw, adr, pcw, a, b, rs, alu, imm, ill, done};
    endfunction

    // One clock cycle: drive inputs just after the rising edge, queue the
    // expected outputs, compare at the falling edge.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [3:0] nst,
                       input logic [6:0] o, input logic [2:0] f3, input logic z,
                       input logic mr);
        logic [21:0] e;
        op = o; funct3 = f3; zero = z; mem_ready = mr;
        expq.push_back(exp_out(st, nst, o, f3, z, mr));
        @(negedge clk);
        e = expq.pop_front();
        if (mem_write)  mw_cnt++;
        if (reg_write)  rw_cnt++;
        if (pc_write)   pw_cnt++;
        if (instr_done) done_cnt++;
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s st%0d: actual=%h required=%h", tag, st, act, e);
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset asynchronously mid-cycle with mem_ready high, check the
    // FETCH reset values, then release just after the next rising edge.
    task automatic reset_pulse(input string tag);
        logic [21:0] e;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        expq.push_back(exp_out(4'd0, 4'd0, op, funct3, zero, 1'b0));
        #2;
        e = expq.pop_front();
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s async: actual=%h required=%h", tag, act, e);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
    endtask

    task automatic clr_counts();
        mw_cnt = 0; rw_cnt = 0; pw_cnt = 0; done_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op = LW; funct3 = 3'b010; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (state !== 4'd0 || pc_write !== 1'b0 || ir_write !== 1'b0 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: actual st=%0d pc=%b ir=%b ill=%b required 0 0 0 0",
                     state, pc_write, ir_write, illegal);
        end
        reset_pulse("reset");
        cyc("reset_first_fetch", 0, 0, LW, 3'b010, 0, 0);
    endtask

    task automatic test_lw();
        clr_counts();
        cyc("lw", 0, 1, LW, 3'b010, 0, 1);
        cyc("lw", 1, 2, LW, 3'b010, 0, 1);
        cyc("lw", 2, 3, LW, 3'b010, 0, 1);
        cyc("lw", 3, 4, LW, 3'b010, 0, 1);
        cyc("lw", 4, 0, LW, 3'b010, 0, 1);
        n_tests++;
        if (rw_cnt !== 1 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL lw_counts: actual rw=%0d done=%0d required 1 1", rw_cnt, done_cnt);
        end
    endtask

    task automatic test_sw_wait();
        clr_counts();
        cyc("sw", 0, 0, SW, 3'b010, 0, 0);
        cyc("sw", 0, 1, SW, 3'b010, 0, 1);
        cyc("sw", 1, 2, SW, 3'b010, 0, 0);
        cyc("sw", 2, 5, SW, 3'b010, 0, 1);
        for (int i = 0; i < 3; i++) cyc("sw_wait", 5, 5, SW, 3'b010, 0, 0);
        cyc("sw", 5, 0, SW, 3'b010, 0, 1);
        n_tests++;
        if (mw_cnt !== 4 || rw_cnt !== 0) begin
            n_fail++;
            $display("FAIL sw_counts: actual mw=%0d rw=%0d required 4 0", mw_cnt, rw_cnt);
        end
    endtask

    task automatic test_branch();
        cyc("beq_z1", 0, 1, BR, 3'b000, 1, 1);
        cyc("beq_z1", 1, 9, BR, 3'b000, 1, 1);
        cyc("beq_z1", 9, 0, BR, 3'b000, 1, 1);
        cyc("bne_z1", 0, 1, BR, 3'b001, 1, 1);
        cyc("bne_z1", 1, 9, BR, 3'b001, 1, 1);
        cyc("bne_z1", 9, 0, BR, 3'b001, 1, 1);
        cyc("bne_z0", 0, 1, BR, 3'b001, 0, 1);
        cyc("bne_z0", 1, 9, BR, 3'b001, 0, 1);
        cyc("bne_z0", 9, 0, BR, 3'b001, 0, 1);
        cyc("beq_z0", 0, 1, BR, 3'b000, 0, 1);
        cyc("beq_z0", 1, 9, BR, 3'b000, 0, 1);
        cyc("beq_z0", 9, 0, BR, 3'b000, 0, 1);
    endtask

    task automatic test_jumps();
        clr_counts();
        cyc("jalr", 0, 1, JALR, 3'b000, 0, 1);
        cyc("jalr", 1, 11, JALR, 3'b000, 0, 1);
        cyc("jalr", 11, 12, JALR, 3'b000, 0, 1);
        cyc("jalr", 12, 8, JALR, 3'b000, 0, 1);
        cyc("jalr", 8, 0, JALR, 3'b000, 0, 1);
        n_tests++;
        if (pw_cnt !== 2 || rw_cnt !== 1) begin
            n_fail++;
            $display("FAIL jalr_counts: actual pw=%0d rw=%0d required 2 1", pw_cnt, rw_cnt);
        end
        cyc("jal", 0, 1, JAL, 3'b000, 0, 1);
        cyc("jal", 1, 10, JAL, 3'b000, 0, 1);
        cyc("jal", 10, 8, JAL, 3'b000, 0, 1);
        cyc("jal", 8, 0, JAL, 3'b000, 0, 1);
    endtask

    task automatic test_alu_ops();
        cyc("rtype", 0, 1, RT, 3'b000, 0, 1);
        cyc("rtype", 1, 6, RT, 3'b000, 0, 1);
        cyc("rtype", 6, 8, RT, 3'b000, 0, 1);
        cyc("rtype", 8, 0, RT, 3'b000, 0, 1);
        cyc("itype", 0, 1, IT, 3'b000, 0, 1);
        cyc("itype", 1, 7, IT, 3'b000, 0, 1);
        cyc("itype", 7, 8, IT, 3'b000, 0, 1);
        cyc("itype", 8, 0, IT, 3'b000, 0, 1);
    endtask

    task automatic test_illegal();
        cyc("illegal", 0, 1, BAD, 3'b000, 0, 1);
        cyc("illegal", 1, 15, BAD, 3'b000, 0, 1);
        for (int i = 0; i < 3; i++) cyc("illegal_hold", 15, 15, BAD, 3'b000, 0, 1);
        reset_pulse("illegal_reset");
        cyc("after_illegal", 0, 1, BR, 3'b010, 0, 1);
        cyc("bad_funct3", 1, 15, BR, 3'b010, 0, 1);
        cyc("bad_funct3", 15, 15, BR, 3'b010, 0, 0);
        reset_pulse("bad_funct3_reset");
    endtask

    task automatic test_reset_midread();
        clr_counts();
        cyc("midread", 0, 1, LW, 3'b010, 0, 1);
        cyc("midread", 1, 2, LW, 3'b010, 0, 1);
        cyc("midread", 2, 3, LW, 3'b010, 0, 0);
        cyc("midread", 3, 3, LW, 3'b010, 0, 0);
        cyc("midread", 3, 3, LW, 3'b010, 0, 0);
        reset_pulse("midread_reset");
        cyc("midread_after", 0, 1, IT, 3'b000, 0, 1);
        n_tests++;
        if (rw_cnt !== 0) begin
            n_fail++;
            $display("FAIL midread_no_regwrite: actual rw=%0d required 0", rw_cnt);
        end
        cyc("midread_after", 1, 7, IT, 3'b000, 0, 0);
        cyc("midread_after", 7, 8, IT, 3'b000, 0, 0);
        cyc("midread_after", 8, 0, IT, 3'b000, 0, 0);
    endtask

    task automatic test_back_to_back();
        clr_counts();
        cyc("b2b_lw", 0, 1, LW, 3'b010, 0, 1);
        cyc("b2b_lw", 1, 2, LW, 3'b010, 0, 1);
        cyc("b2b_lw", 2, 3, LW, 3'b010, 0, 1);
        cyc("b2b_lw", 3, 4, LW, 3'b010, 0, 1);
        cyc("b2b_lw", 4, 0, LW, 3'b010, 0, 1);
        cyc("b2b_sw", 0, 1, SW, 3'b010, 0, 1);
        cyc("b2b_sw", 1, 2, SW, 3'b010, 0, 1);
        cyc("b2b_sw", 2, 5, SW, 3'b010, 0, 1);
        cyc("b2b_sw", 5, 0, SW, 3'b010, 0, 1);
        n_tests++;
        if (done_cnt !== 2 || mw_cnt !== 1) begin
            n_fail++;
            $display("FAIL b2b_counts: actual done=%0d mw=%0d required 2 1", done_cnt, mw_cnt);
        end
    endtask

    initial begin
        clr_counts();
        test_reset();
        test_lw();
        test_sw_wait();
        test_branch();
        test_jumps();
        test_alu_ops();
        test_illegal();
        test_reset_midread();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port op, input, 7 bits: opcode from the instruction register.
REQ-004 SHALL have port funct3, input, 3 bits: from the instruction register.
REQ-005 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1 bit: memory completes the current access this cycle.
REQ-007 SHALL have outputs mem_req, mem_write, ir_write, reg_write, adr_src, 1 bit each: memory request, store enable, IR load, register-file write, address mux select (0=PC, 1=result).
REQ-008 SHALL have output pc_write, 1 bit: PC load enable.
REQ-009 SHALL have outputs alu_src_a, alu_src_b, result_src, alu_op, imm_src, 2 bits each.
REQ-010 SHALL have output illegal, 1 bit: sticky unsupported-instruction flag.
REQ-011 SHALL have output instr_done, 1 bit: one-cycle retire pulse.
REQ-012 SHALL have output state, 4 bits: current state code, for debug.

Function
REQ-013 Encodings SHALL be:
- alu_src_a: 00=PC, 01=OldPC, 10=rs1.
- alu_src_b: 00=rs2, 01=imm, 10=constant 4.
- result_src: 00=ALUOut, 01=MemData, 10=ALUResult.
- alu_op: 00=add, 01=sub, 10=funct-decoded.
REQ-014 State codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, JLINK=12, ILLEGAL=15.
REQ-015 Outputs SHALL be Moore outputs of state only, except for:
- pc_write, which also depends on funct3/zero;
- ir_write/pc_write in FETCH, which also depend on mem_ready;
- imm_src, which depends on op.
REQ-016 imm_src SHALL be combinational from op: 0000011/0010011/1100111 -> 00; 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; any other op -> 00.
REQ-017 All signals not listed for a state SHALL be 0.
REQ-018 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10; ir_write=pc_write=mem_ready.
- Stay in FETCH while mem_ready=0.
- Go to DECODE when mem_ready=1.
REQ-019 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch/JAL target into ALUOut). Next state by op:
- 0000011 or 0100011 -> MEMADR;
- 0110011 -> EXECR;
- 0010011 -> EXECI;
- 1100011 with funct3 000 or 001 -> BRANCH;
- 1101111 -> JAL;
- 1100111 -> JALR;
- anything else -> ILLEGAL.
REQ-020 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next is MEMREAD if op[5]=0, else MEMWRITE.
REQ-021 MEMREAD: mem_req=1, adr_src=1, result_src=00. Hold until mem_ready=1, then go to MEMWB.
REQ-022 MEMWRITE: mem_req=1, adr_src=1, result_src=00, mem_write=1. Hold until mem_ready=1, then go to FETCH.
REQ-023 MEMWB: result_src=01, reg_write=1, then FETCH.
REQ-024 EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
REQ-025 EXECI: alu_src_a=10, alu_src_b=01, alu_op=10, then ALUWB.
REQ-026 ALUWB: result_src=00, reg_write=1, then FETCH.
REQ-027 BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00. pc_write = (funct3[0]=0 & zero) | (funct3[0]=1 & ~zero). Next is FETCH.
REQ-028 JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1, then ALUWB.
REQ-029 JALR: alu_src_a=10, alu_src_b=01, alu_op=00, result_src=10, pc_write=1, then JLINK.
REQ-030 JLINK: alu_src_a=01, alu_src_b=10, alu_op=00, then ALUWB.
REQ-031 instr_done SHALL be 1 exactly in the cycle whose next state is FETCH from a non-FETCH state.
REQ-032 ILLEGAL: all writes and mem_req 0, illegal=1; remains in ILLEGAL until reset.
REQ-033 mem_ready SHALL be ignored in states that do not assert mem_req.
REQ-034 A mem_ready high for several cycles SHALL complete only one access per visit to FETCH, MEMREAD or MEMWRITE.

Reset
REQ-035 While rst_n=0, state SHALL be FETCH, illegal=0, instr_done=0, and all write enables (pc_write, ir_write, reg_write, mem_write) SHALL be 0, regardless of clk. mem_req, adr_src, alu_src_a, alu_src_b, alu_op and result_src take their FETCH values from REQ-018.
REQ-036 Reset asserted mid-instruction (including during a pending memory access) SHALL abort it with no further writes.
REQ-037 After rst_n rises, the first access SHALL be a FETCH request.

Verification
REQ-038 lw (op 0000011), mem_ready=1 whenever requested -> states 0,1,2,3,4,0; reg_write only in MEMWB; instr_done in cycle 5.
REQ-039 sw with mem_ready held 0 for 3 cycles in MEMWRITE -> mem_write=1 for 4 cycles, then FETCH; no reg_write.
REQ-040 beq with zero=1 -> pc_write=1 in BRANCH; bne (funct3=001) with zero=1 -> pc_write=0.
REQ-041 jalr -> states 0,1,11,12,8,0; pc_write in FETCH and JALR only; reg_write in ALUWB with result_src=00.
REQ-042 op=1111111 -> ILLEGAL after DECODE, illegal=1 and held; rst_n=0 then 1 -> FETCH, illegal=0.
REQ-043 rst_n low during MEMREAD while waiting on mem_ready -> immediate FETCH, reg_write never asserted.
